// File: rtl/idex_pipe_reg.sv
// ID->EX pipeline register, 1-cycle D->E latency, zero-latency NZCV forwarding into FlagsE.
// Backpressure: StallE holds every E field, FlushE (wins over stall) loads a bubble; IDEX_PERF_CNT_EN adds stall/bubble counters.
module idex_pipe_reg #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallE,
  input  logic          FlushE,
  input  logic          ValidD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          MemWriteD,
  input  logic          BranchD,
  input  logic          ALUSrcD,
  input  logic [1:0]    ALUControlD,
  input  logic [1:0]    FlagWriteD,
  input  logic [3:0]    CondD,
  input  logic [DW-1:0] RD1D,
  input  logic [DW-1:0] RD2D,
  input  logic [DW-1:0] ExtImmD,
  input  logic [AW-1:0] RA1D,
  input  logic [AW-1:0] RA2D,
  input  logic [AW-1:0] WA3D,
  input  logic [3:0]    Flags,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagWE,
  output logic          ValidE,
  output logic          RegWriteE,
  output logic          MemtoRegE,
  output logic          MemWriteE,
  output logic          BranchE,
  output logic          ALUSrcE,
  output logic [1:0]    ALUControlE,
  output logic [1:0]    FlagWriteE,
  output logic [3:0]    CondE,
  output logic [3:0]    FlagsE,
  output logic [DW-1:0] RD1E,
  output logic [DW-1:0] RD2E,
  output logic [DW-1:0] ExtImmE,
  output logic [AW-1:0] RA1E,
  output logic [AW-1:0] RA2E,
  output logic [AW-1:0] WA3E,
  output logic [31:0]   StallCount,
  output logic [31:0]   BubbleCount
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic          branch;
    logic          alu_src;
    logic [1:0]    alu_control;
    logic [1:0]    flag_write;
    logic [3:0]    cond;
    logic [3:0]    flags;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] ext_imm;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa3;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (FlushE) begin
      stage_d = '0;
    end else if (!StallE) begin
      stage_d.valid       = ValidD;
      stage_d.reg_write   = RegWriteD;
      stage_d.mem_to_reg  = MemtoRegD;
      stage_d.mem_write   = MemWriteD;
      stage_d.branch      = BranchD;
      stage_d.alu_src     = ALUSrcD;
      stage_d.alu_control = ALUControlD;
      stage_d.flag_write  = FlagWriteD;
      stage_d.cond        = CondD;
      // Mirror what the flag register will hold after this edge
      stage_d.flags[3:2]  = FlagWE[1] ? ALUFlags[3:2] : Flags[3:2];
      stage_d.flags[1:0]  = FlagWE[0] ? ALUFlags[1:0] : Flags[1:0];
      stage_d.rd1         = RD1D;
      stage_d.rd2         = RD2D;
      stage_d.ext_imm     = ExtImmD;
      stage_d.ra1         = RA1D;
      stage_d.ra2         = RA2D;
      stage_d.wa3         = WA3D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign ValidE      = stage_q.valid;
  assign RegWriteE   = stage_q.reg_write;
  assign MemtoRegE   = stage_q.mem_to_reg;
  assign MemWriteE   = stage_q.mem_write;
  assign BranchE     = stage_q.branch;
  assign ALUSrcE     = stage_q.alu_src;
  assign ALUControlE = stage_q.alu_control;
  assign FlagWriteE  = stage_q.flag_write;
  assign CondE       = stage_q.cond;
  assign FlagsE      = stage_q.flags;
  assign RD1E        = stage_q.rd1;
  assign RD2E        = stage_q.rd2;
  assign ExtImmE     = stage_q.ext_imm;
  assign RA1E        = stage_q.ra1;
  assign RA2E        = stage_q.ra2;
  assign WA3E        = stage_q.wa3;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_count_d, stall_count_q;
  logic [31:0] bubble_count_d, bubble_count_q;

  // A flush cycle counts as a bubble only, never as a stall
  always_comb begin
    stall_count_d  = stall_count_q;
    bubble_count_d = bubble_count_q;
    if (FlushE)      bubble_count_d = bubble_count_q + 32'd1;
    else if (StallE) stall_count_d  = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_count_q  <= stall_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign StallCount  = stall_count_q;
  assign BubbleCount = bubble_count_q;
`else
  assign StallCount  = '0;
  assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: directed sequences, a flag-forwarding vector table and a randomized run
// against a field-level reference model.
module tb_idex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef IDEX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, StallE, FlushE, ValidD;
  logic RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWriteD, FlagWE;
  logic [3:0] CondD, Flags, ALUFlags;
  logic [DW-1:0] RD1D, RD2D, ExtImmD;
  logic [AW-1:0] RA1D, RA2D, WA3D;
  logic ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0] ALUControlE, FlagWriteE;
  logic [3:0] CondE, FlagsE;
  logic [DW-1:0] RD1E, RD2E, ExtImmE;
  logic [AW-1:0] RA1E, RA2E, WA3E;
  logic [31:0] StallCount, BubbleCount;

  typedef struct packed {
    logic valid, rw, m2r, mw, br, asrc;
    logic [1:0] actl, fw;
    logic [3:0] cond, flags;
    logic [DW-1:0] rd1, rd2, imm;
    logic [AW-1:0] ra1, ra2, wa3;
  } out_t;

  typedef struct {
    logic stall, flush;
    logic [3:0] flags, alu_flags;
    logic [1:0] we;
    logic [3:0] exp_flags_e;
  } vec_t;

  out_t dut_out, model;
  logic [31:0] exp_stall, exp_bubble;
  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[8];

  assign dut_out = {ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
                    FlagWriteE, CondE, FlagsE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E};

  idex_pipe_reg #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .Flags(Flags), .ALUFlags(ALUFlags), .FlagWE(FlagWE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .FlagsE(FlagsE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .StallCount(StallCount), .BubbleCount(BubbleCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_d();
    ValidD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; ALUSrcD = 0;
    ALUControlD = 0; FlagWriteD = 0; CondD = 0; RD1D = 0; RD2D = 0; ExtImmD = 0;
    RA1D = 0; RA2D = 0; WA3D = 0; Flags = 0; ALUFlags = 0; FlagWE = 0;
  endtask

  task automatic rand_d();
    ValidD = 1'($urandom); RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom);
    MemWriteD = 1'($urandom); BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
    ALUControlD = 2'($urandom); FlagWriteD = 2'($urandom); CondD = 4'($urandom);
    RD1D = DW'($urandom); RD2D = DW'($urandom); ExtImmD = DW'($urandom);
    RA1D = AW'($urandom); RA2D = AW'($urandom); WA3D = AW'($urandom);
    Flags = 4'($urandom); ALUFlags = 4'($urandom); FlagWE = 2'($urandom);
  endtask

  initial begin
    vecs[0] = '{0, 0, 4'b0000, 4'b0100, 2'b10, 4'b0100};
    vecs[1] = '{0, 0, 4'b0000, 4'b0011, 2'b01, 4'b0011};
    vecs[2] = '{0, 0, 4'b1000, 4'b0111, 2'b00, 4'b1000};
    vecs[3] = '{1, 0, 4'b0000, 4'b0111, 2'b11, 4'b1000};
    vecs[4] = '{0, 0, 4'b1010, 4'b0101, 2'b11, 4'b0101};
    vecs[5] = '{0, 0, 4'b1010, 4'b0101, 2'b10, 4'b0110};
    vecs[6] = '{0, 0, 4'b1010, 4'b0101, 2'b01, 4'b1001};
    vecs[7] = '{0, 1, 4'b1111, 4'b1111, 2'b11, 4'b0000};

    // Reset with random D inputs
    reset = 1; StallE = 0; FlushE = 0;
    rand_d();
    step();
    rand_d();
    step();
    check("reset_outputs", 256'(dut_out), 256'(0));
    check("reset_stall_cnt", 256'(StallCount), 256'(0));
    check("reset_bubble_cnt", 256'(BubbleCount), 256'(0));

    // First advance after reset
    reset = 0;
    zero_d();
    ValidD = 1; RegWriteD = 1; CondD = 4'hE; RD1D = 32'h1234;
    step();
    check("adv_regwrite", 256'(RegWriteE), 256'(1));
    check("adv_cond", 256'(CondE), 256'(4'hE));
    check("adv_rd1", 256'(RD1E), 256'(32'h1234));

    // Stall holds for 3 cycles
    zero_d();
    CondD = 4'h0; RD2D = 32'hAA;
    step();
    check("pre_stall_rd2", 256'(RD2E), 256'(32'hAA));
    StallE = 1; RD2D = 32'hBB; CondD = 4'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rd2_hold", 256'(RD2E), 256'(32'hAA));
      check("stall_cond_hold", 256'(CondE), 256'(4'h0));
    end
    StallE = 0;
    step();
    check("stall_release_rd2", 256'(RD2E), 256'(32'hBB));
    check("stall_count", 256'(StallCount), 256'(PERF ? 32'd3 : 32'd0));

    // Flush wins over stall
    zero_d();
    ValidD = 1; MemWriteD = 1; FlagWriteD = 2'b11;
    step();
    check("pre_flush_memwrite", 256'(MemWriteE), 256'(1));
    StallE = 1; FlushE = 1;
    step();
    check("flush_memwrite", 256'(MemWriteE), 256'(0));
    check("flush_valid", 256'(ValidE), 256'(0));
    check("flush_flagwrite", 256'(FlagWriteE), 256'(0));
    check("flush_bubble_cnt", 256'(BubbleCount), 256'(PERF ? 32'd1 : 32'd0));
    check("flush_stall_cnt", 256'(StallCount), 256'(PERF ? 32'd3 : 32'd0));
    StallE = 0; FlushE = 0;

    // Flag forwarding / hold vectors
    zero_d();
    foreach (vecs[i]) begin
      StallE = vecs[i].stall; FlushE = vecs[i].flush;
      Flags = vecs[i].flags; ALUFlags = vecs[i].alu_flags; FlagWE = vecs[i].we;
      step();
      check($sformatf("flags_vec%0d", i), 256'(FlagsE), 256'(vecs[i].exp_flags_e));
    end
    StallE = 0; FlushE = 0;

`ifdef IDEX_PERF_CNT_EN
    // Counter wrap
    force dut.stall_count_q = 32'hFFFFFFFF;
    #1;
    release dut.stall_count_q;
    StallE = 1;
    step();
    check("stall_cnt_wrap", 256'(StallCount), 256'(0));
    StallE = 0;
`endif

    // Randomized run against the reference model
    model = '0; exp_stall = 0; exp_bubble = 0;
    for (int i = 0; i < 2000; i++) begin
      reset  = (i == 0) || ($urandom_range(0, 63) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      rand_d();
      if (reset) begin
        model = '0; exp_stall = 0; exp_bubble = 0;
      end else if (FlushE) begin
        model = '0;
        if (PERF) exp_bubble = exp_bubble + 1;
      end else if (StallE) begin
        if (PERF) exp_stall = exp_stall + 1;
      end else begin
        model = '{valid: ValidD, rw: RegWriteD, m2r: MemtoRegD, mw: MemWriteD, br: BranchD,
                  asrc: ALUSrcD, actl: ALUControlD, fw: FlagWriteD, cond: CondD,
                  flags: {(FlagWE[1] ? ALUFlags[3:2] : Flags[3:2]),
                          (FlagWE[0] ? ALUFlags[1:0] : Flags[1:0])},
                  rd1: RD1D, rd2: RD2D, imm: ExtImmD, ra1: RA1D, ra2: RA2D, wa3: WA3D};
      end
      step();
      check("rand_outputs", 256'(dut_out), 256'(model));
      check("rand_stall_cnt", 256'(StallCount), 256'(exp_stall));
      check("rand_bubble_cnt", 256'(BubbleCount), 256'(exp_bubble));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
